// File: rtl/multicycle_ctrl_unit.sv
// multicycle_ctrl_unit
//   Multi-cycle RV32I/RV64I control unit. Each instruction walks through
//   IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> WB -> FETCH. Datapath control
//   fields are registered in DECODE and hold until the next DECODE. The PC
//   and register-file write enables pulse once, in WB. ebreak and a
//   memory-wait watchdog park the unit in HALT until reset.
//
// Build option: define NPC_ILLEGAL_TRAP_EN to trap unknown instructions
//   into HALT with the illegal flag set. Without it, unknown instructions
//   retire as a NOP and illegal is tied to 0.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   inst                  instruction from IFU, sampled when ifu_ack=1
//   ifu_req / ifu_ack     fetch handshake
//   lsu_req / lsu_ack     data access handshake
//   IS_ZERO, LESS         ALU flags, sampled in EXEC
//   op_IMM, op_ALU_*      immediate type, ALU operand selects, ALU op
//   word_op               32-bit op with sign-extended result (XLEN=64 only)
//   load, store, op_PMEM, op_load_sext   memory access controls
//   en_Wreg, pc_we        single-cycle write pulses in WB
//   op_PC_Asrc/Bsrc       next-PC operand selects, registered in EXEC
//   halted, timeout, illegal   sticky status flags
//   state                 current FSM state for debug
//
// Handshake: a request is held high while its state waits and drops in the
// same cycle the matching ack is seen (req = waiting && !ack). An ack is
// only honoured in the state that issued the request; anything else is
// ignored.
module multicycle_ctrl_unit #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    output logic        ifu_req,
    input  logic        ifu_ack,
    output logic        lsu_req,
    input  logic        lsu_ack,
    input  logic        IS_ZERO,
    input  logic        LESS,
    output logic [2:0]  op_IMM,
    output logic        op_ALU_Asrc,
    output logic [1:0]  op_ALU_Bsrc,
    output logic [3:0]  op_ALU_sel,
    output logic        word_op,
    output logic        load,
    output logic        store,
    output logic [7:0]  op_PMEM,
    output logic [1:0]  op_load_sext,
    output logic        en_Wreg,
    output logic        pc_we,
    output logic        op_PC_Asrc,
    output logic        op_PC_Bsrc,
    output logic        halted,
    output logic        timeout,
    output logic        illegal,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
        S_MEM  = 3'd4, S_WB    = 3'd5, S_HALT   = 3'd6
    } state_t;

    localparam logic [2:0] IMM_I = 3'd0, IMM_U = 3'd1, IMM_B = 3'd2,
                           IMM_S = 3'd3, IMM_J = 3'd4;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2,
                           ALU_SLT = 4'd3, ALU_SLTU = 4'd4, ALU_XOR = 4'd5,
                           ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR = 4'd8,
                           ALU_AND = 4'd9, ALU_COPYB = 4'd10;
    localparam logic [7:0] PM_BYTE = 8'h01, PM_HALF = 8'h03,
                           PM_WORD = 8'h0F, PM_DOUBLE = 8'hFF;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam bit RV64  = (XLEN == 64);
    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           cur, nxt;
    logic [31:0]      inst_q;
    logic [CNT_W-1:0] wd_cnt;
    logic             wd_fire;
    logic             wreg_q, br_q, jal_q, jalr_q, taken;

    // decoded fields, combinational from inst_q
    logic [2:0] d_imm;
    logic       d_asrc, d_word, d_load, d_store, d_wreg, d_br, d_jal, d_jalr, d_known;
    logic [1:0] d_bsrc, d_sext;
    logic [3:0] d_sel;
    logic [7:0] d_pmem;
    logic [6:0] opc;
    logic [2:0] f3;

    assign opc   = inst_q[6:0];
    assign f3    = inst_q[14:12];
    assign state = cur;
    assign wd_fire = WD_EN && (wd_cnt == WD_LAST);

    function automatic logic [3:0] alu_f3(input logic [2:0] fn, input logic alt);
        case (fn)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        d_imm = IMM_I; d_asrc = 1'b0; d_bsrc = 2'b00; d_sel = ALU_ADD;
        d_word = 1'b0; d_load = 1'b0; d_store = 1'b0; d_pmem = 8'h00;
        d_sext = 2'b00; d_wreg = 1'b0; d_br = 1'b0; d_jal = 1'b0;
        d_jalr = 1'b0; d_known = 1'b1;
        case (opc)
            7'b0110111: begin d_imm = IMM_U; d_bsrc = 2'b01; d_sel = ALU_COPYB; d_wreg = 1'b1; end
            7'b0010111: begin d_imm = IMM_U; d_asrc = 1'b1; d_bsrc = 2'b01; d_wreg = 1'b1; end
            7'b1101111: begin d_imm = IMM_J; d_asrc = 1'b1; d_bsrc = 2'b10; d_wreg = 1'b1; d_jal = 1'b1; end
            7'b1100111: begin
                d_imm = IMM_I; d_asrc = 1'b1; d_bsrc = 2'b10; d_wreg = 1'b1; d_jalr = 1'b1;
                d_known = (f3 == 3'b000);
            end
            7'b1100011: begin
                d_imm = IMM_B; d_br = 1'b1;
                case (f3)
                    3'b000, 3'b001: d_sel = ALU_SUB;
                    3'b100, 3'b101: d_sel = ALU_SLT;
                    3'b110, 3'b111: d_sel = ALU_SLTU;
                    default:        d_known = 1'b0;
                endcase
            end
            7'b0000011: begin
                d_imm = IMM_I; d_bsrc = 2'b01; d_load = 1'b1; d_wreg = 1'b1;
                case (f3)
                    3'b000:  begin d_pmem = PM_BYTE; d_sext = 2'b01; end
                    3'b001:  begin d_pmem = PM_HALF; d_sext = 2'b10; end
                    3'b010:  begin d_pmem = PM_WORD; d_sext = RV64 ? 2'b11 : 2'b00; end
                    3'b100:  d_pmem = PM_BYTE;
                    3'b101:  d_pmem = PM_HALF;
                    3'b110:  begin d_pmem = PM_WORD;   d_known = RV64; end
                    3'b011:  begin d_pmem = PM_DOUBLE; d_known = RV64; end
                    default: d_known = 1'b0;
                endcase
            end
            7'b0100011: begin
                d_imm = IMM_S; d_bsrc = 2'b01; d_store = 1'b1;
                case (f3)
                    3'b000:  d_pmem = PM_BYTE;
                    3'b001:  d_pmem = PM_HALF;
                    3'b010:  d_pmem = PM_WORD;
                    3'b011:  begin d_pmem = PM_DOUBLE; d_known = RV64; end
                    default: d_known = 1'b0;
                endcase
            end
            // bit 30 only selects SRA for immediates; for addi it is an
            // ordinary immediate bit and must not turn ADD into SUB.
            7'b0010011: begin
                d_bsrc = 2'b01; d_wreg = 1'b1;
                d_sel = alu_f3(f3, inst_q[30] && (f3 == 3'b101));
            end
            7'b0110011: begin d_wreg = 1'b1; d_sel = alu_f3(f3, inst_q[30]); end
            7'b0011011: begin
                d_bsrc = 2'b01; d_word = 1'b1; d_wreg = 1'b1;
                d_sel = alu_f3(f3, inst_q[30] && (f3 == 3'b101));
                d_known = RV64 && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101);
            end
            7'b0111011: begin
                d_word = 1'b1; d_wreg = 1'b1; d_sel = alu_f3(f3, inst_q[30]);
                d_known = RV64 && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101);
            end
            7'b0001111, 7'b1110011: ;   // fence / system: retire without a write
            default: d_known = 1'b0;
        endcase
        // Unknown instructions retire as a plain PC+4 NOP.
        if (!d_known) begin
            d_imm = IMM_I; d_asrc = 1'b0; d_bsrc = 2'b00; d_sel = ALU_ADD;
            d_word = 1'b0; d_load = 1'b0; d_store = 1'b0; d_pmem = 8'h00;
            d_sext = 2'b00; d_wreg = 1'b0; d_br = 1'b0; d_jal = 1'b0; d_jalr = 1'b0;
        end
    end

    always_comb begin
        case (f3)
            3'b000:         taken = IS_ZERO;
            3'b001:         taken = !IS_ZERO;
            3'b100, 3'b110: taken = LESS;
            3'b101, 3'b111: taken = !LESS;
            default:        taken = 1'b0;
        endcase
    end

    always_comb begin
        nxt = cur; ifu_req = 1'b0; lsu_req = 1'b0; pc_we = 1'b0; en_Wreg = 1'b0;
        case (cur)
            S_IDLE:  nxt = S_FETCH;
            S_FETCH: begin
                ifu_req = !ifu_ack;
                if (ifu_ack)      nxt = S_DECODE;   // ack beats the watchdog
                else if (wd_fire) nxt = S_HALT;
            end
            S_DECODE: begin
                if (inst_q == EBREAK) nxt = S_HALT;
`ifdef NPC_ILLEGAL_TRAP_EN
                else if (!d_known)    nxt = S_HALT;
`endif
                else                  nxt = S_EXEC;
            end
            S_EXEC: nxt = (load || store) ? S_MEM : S_WB;
            S_MEM: begin
                lsu_req = !lsu_ack;
                if (lsu_ack)      nxt = S_WB;
                else if (wd_fire) nxt = S_HALT;
            end
            S_WB: begin pc_we = 1'b1; en_Wreg = wreg_q; nxt = S_FETCH; end
            S_HALT:  nxt = S_HALT;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= S_IDLE; inst_q <= '0; wd_cnt <= '0;
            op_IMM <= '0; op_ALU_Asrc <= 1'b0; op_ALU_Bsrc <= '0; op_ALU_sel <= '0;
            word_op <= 1'b0; load <= 1'b0; store <= 1'b0; op_PMEM <= '0;
            op_load_sext <= '0; wreg_q <= 1'b0; br_q <= 1'b0; jal_q <= 1'b0;
            jalr_q <= 1'b0; op_PC_Asrc <= 1'b0; op_PC_Bsrc <= 1'b0;
            halted <= 1'b0; timeout <= 1'b0;
        end else begin
            cur <= nxt;
            if (cur == S_FETCH && ifu_ack) inst_q <= inst;
            // Counts wait cycles; any other state clears it, so entry is 0.
            if ((cur == S_FETCH && !ifu_ack) || (cur == S_MEM && !lsu_ack))
                wd_cnt <= wd_cnt + 1'b1;
            else
                wd_cnt <= '0;
            if (cur == S_DECODE) begin
                op_IMM <= d_imm; op_ALU_Asrc <= d_asrc; op_ALU_Bsrc <= d_bsrc;
                op_ALU_sel <= d_sel; word_op <= d_word; load <= d_load;
                store <= d_store; op_PMEM <= d_pmem; op_load_sext <= d_sext;
                wreg_q <= d_wreg; br_q <= d_br; jal_q <= d_jal; jalr_q <= d_jalr;
            end
            if (cur == S_EXEC) begin
                op_PC_Asrc <= (br_q && taken) || jal_q || jalr_q;
                op_PC_Bsrc <= jalr_q;
            end
            if (nxt == S_HALT && cur != S_HALT) halted <= 1'b1;
            if ((cur == S_FETCH || cur == S_MEM) && nxt == S_HALT) timeout <= 1'b1;
        end
    end

`ifdef NPC_ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal_q <= 1'b0;
        else if (cur == S_DECODE && nxt == S_HALT && inst_q != EBREAK)
            illegal_q <= 1'b1;
    end
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: doc/multicycle_ctrl_unit.md
Name: multicycle_ctrl_unit

Overview:
- Multi-cycle successor to the single-cycle NPC decoder.
- Sequences each RV32I/RV64I instruction through FETCH, DECODE, EXEC, MEM and WB with valid/ack handshakes to the IFU and LSU.
- Registers all datapath control fields; pulses register-file and PC write enables exactly once per instruction.
- Owns halt (ebreak) and a memory-wait watchdog.

Parameters:
- XLEN, 32, datapath width. Must be 32 or 64. 64 enables ld/sd/lwu and OP-32/OP-IMM-32 decoding.
- TIMEOUT_CYCLES, 1024, max wait cycles per memory handshake. 0 disables the watchdog.
- CNT_W, 16, width of the watchdog counter. Must satisfy CNT_W ≥ clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- inst  in  32  instruction from IFU; valid when ifu_ack=1
- ifu_req  out  1  fetch request
- ifu_ack  in  1  fetch complete
- lsu_req  out  1  data access request
- lsu_ack  in  1  data access complete
- IS_ZERO  in  1  ALU result is zero
- LESS  in  1  ALU compare result
- op_IMM  out  3  immediate type (immI/immU/immB/immS/immJ from TYPES.v)
- op_ALU_Asrc  out  1  0=rs1, 1=PC
- op_ALU_Bsrc  out  2  00=rs2, 01=imm, 10=constant 4
- op_ALU_sel  out  4  ALU op code from TYPES.v
- word_op  out  1  32-bit op with sign-extended result; always 0 when XLEN=32
- load  out  1  write-back source is LSU
- store  out  1  access is a write
- op_PMEM  out  8  byte mask (BYTE/HALF_WORD/WORD, plus DOUBLE when XLEN=64)
- op_load_sext  out  2  00=none, 01=byte, 10=half, 11=word
- en_Wreg  out  1  one-cycle register-file write pulse
- pc_we  out  1  one-cycle PC update pulse
- op_PC_Asrc  out  1  next-PC operand A select
- op_PC_Bsrc  out  1  next-PC operand B select (jalr)
- halted  out  1  sticky halt flag
- timeout  out  1  sticky watchdog flag
- illegal  out  1  sticky illegal-instruction flag (with optional feature only)
- state  out  3  current FSM state, for debug

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0, internal inst register 0, watchdog counter 0.
  - Reset mid-handshake abandons the request; a late ack after reset is ignored.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- IDLE:
  - Always transitions to FETCH on the next cycle, so the first ifu_req appears in cycle 2 after rst_n rises.
- FETCH:
  - ifu_req=1 until ifu_ack. On ack, latch inst and go to DECODE.
  - ifu_req drops in the same cycle as ack, combinationally with the state.
- DECODE (1 cycle):
  - Register all control fields from the latched inst; they hold stable until the next DECODE.
  - ebreak (inst==32'h00100073) → HALT.
  - Other decodes → EXEC.
- Branch ALU op:
  - beq/bne → SUB.
  - blt/bge → SLT.
  - bltu/bgeu → SLTU.
- EXEC (1 cycle):
  - Sample IS_ZERO and LESS.
  - Branch taken condition:
    - beq: IS_ZERO
    - bne: !IS_ZERO
    - blt/bltu: LESS
    - bge/bgeu: !LESS
  - Taken branch or jal: op_PC_Asrc=1. jalr: op_PC_Asrc=1 and op_PC_Bsrc=1. All others: both 0 (PC+4).
  - Next state: load or store → MEM; otherwise → WB.
- MEM:
  - lsu_req=1 until lsu_ack, then go to WB.
- WB (1 cycle):
  - pc_we=1.
  - en_Wreg=1 for lui, auipc, jal, jalr, OP, OP-IMM, load, and (XLEN=64) OP-32/OP-IMM-32.
  - Store, branch and fence never write.
  - Then → FETCH.
- Watchdog:
  - Counter clears on entry to FETCH and MEM; increments each waiting cycle without ack.
  - When counter==TIMEOUT_CYCLES-1 and no ack: → HALT with timeout=1.
  - An ack in that same cycle wins; no timeout.
- HALT:
  - Absorbing until reset. No requests, no write pulses.
  - halted=1 from the cycle after DECODE of ebreak (or after the timeout).
- Decode with XLEN=32:
  - funct3=011 on load/store is treated as unknown.
  - Opcodes 0011011 and 0111011 are treated as unknown.
- Unknown opcode handling without the optional feature:
  - Executes as a NOP: no en_Wreg, PC+4, still passes through WB.
- Simultaneous signals:
  - ifu_ack outside FETCH and lsu_ack outside MEM are ignored.

Optional Feature:
- Macro: NPC_ILLEGAL_TRAP_EN.
- Defined:
  - Unknown opcode or unsupported funct3 in DECODE → HALT with illegal=1 and halted=1.
  - No pc_we or en_Wreg is issued for that instruction.
- Undefined:
  - The illegal port is tied to 0.
  - Unknown instructions execute as the NOP described in Behaviour.

Test Plan:
- addi x1,x0,5 (0x00500093), ifu_ack after 3 cycles:
  - DECODE gives op_ALU_Bsrc=01 and op_ALU_sel=ADD.
  - en_Wreg and pc_we pulse together for exactly 1 cycle in WB.
  - Total latency from first ifu_req to pc_we = 3+4 cycles.
- beq with IS_ZERO=1 in EXEC → op_PC_Asrc=1 and en_Wreg=0. Same instruction with IS_ZERO=0 → op_PC_Asrc=0.
- lh (funct3=001), lsu_ack after 5 cycles:
  - lsu_req is high for exactly 5 cycles.
  - op_PMEM=HALF_WORD, op_load_sext=10, load=1.
  - en_Wreg pulses once.
- ebreak (0x00100073):
  - halted=1 and state=6.
  - No further ifu_req over 100 cycles, even with ifu_ack held high.
- TIMEOUT_CYCLES=8, ifu_ack never asserted:
  - timeout=1 and halted=1 exactly 8 cycles after ifu_req rises.
  - Repeat with ack on the 8th cycle → no timeout.
- Reset asserted during MEM with lsu_req=1:
  - All outputs 0 immediately, state=0.
  - Stale lsu_ack in the next cycle is ignored.
  - FETCH resumes normally.
